// File: rtl/axi4_bus_rd_sequencer_pkg.sv
// Shared types and response codes for the AXI4 register-target read sequencer.
package axi4_bus_rd_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam int unsigned TimerW = 8;
    localparam int unsigned ErrW   = 8;

    function automatic logic [ErrW-1:0] sat_inc(input logic [ErrW-1:0] v);
        return (v == {ErrW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axi4_bus_rd_sequencer_if.sv
// FIFO-side and target-side signal bundle for the read sequencer.
interface axi4_bus_rd_sequencer_if #(
    parameter int unsigned A     = 32,
    parameter int unsigned D     = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned WIN_W = 12
);
    logic             ar_rd_empty;
    logic             ar_rd_en;
    logic [A-1:0]     araddr;
    logic             r_wr_full;
    logic             r_wr_en;
    logic [D-1:0]     rdata;
    logic [1:0]       rresp;
    logic             tgt_req;
    logic [N-1:0]     tgt_sel;
    logic [WIN_W-1:0] tgt_addr;
    logic [N-1:0]     tgt_ack;
    logic [N*D-1:0]   tgt_rdata;
    logic [7:0]       err_count;

    // Sequencer side.
    modport master (
        input  ar_rd_empty, araddr, r_wr_full, tgt_ack, tgt_rdata,
        output ar_rd_en, r_wr_en, rdata, rresp, tgt_req, tgt_sel, tgt_addr, err_count
    );

    // FIFO and target side.
    modport slave (
        output ar_rd_empty, araddr, r_wr_full, tgt_ack, tgt_rdata,
        input  ar_rd_en, r_wr_en, rdata, rresp, tgt_req, tgt_sel, tgt_addr, err_count
    );

endinterface

// File: rtl/axi4_bus_rd_sequencer.sv
// Pops AR entries, decodes them onto N register targets, waits for ack or timeout,
// and pushes one R entry per popped address.
module axi4_bus_rd_sequencer
    import axi4_bus_rd_sequencer_pkg::*;
#(
    parameter int unsigned A       = 32,
    parameter int unsigned D       = 32,
    parameter int unsigned N       = 4,
    parameter int unsigned WIN_W   = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    axi4_bus_rd_sequencer_if.master  bus
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HI = WIN_W + IW;
    localparam logic [TimerW-1:0] TO = TimerW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [HI-1:0]     addr_q, addr_d;
    logic [D-1:0]      rdata_q, rdata_d;
    resp_t             rresp_q, rresp_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [ErrW-1:0]   err_q, err_d;

    logic [IW-1:0]     idx;
    logic [D-1:0]      sel_rdata;
    logic              sel_ack;
    logic              miss;

    // Only the window offset and target index are kept; upper bits just feed the miss check.
    assign idx       = addr_q[WIN_W +: IW];
    assign sel_rdata = bus.tgt_rdata[idx*D +: D];
    assign sel_ack   = bus.tgt_ack[idx];
    assign miss      = (bus.araddr >> HI) != '0;

    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign bus.err_count = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            timer_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        timer_d      = timer_q;
        err_d        = err_q;
        bus.ar_rd_en = 1'b0;
        bus.r_wr_en  = 1'b0;
        bus.tgt_req  = 1'b0;
        bus.tgt_sel  = '0;
        bus.tgt_addr = '0;

        unique case (state_q)
            StIdle: begin
                if (!bus.ar_rd_empty) begin
                    bus.ar_rd_en = 1'b1;
                    addr_d       = bus.araddr[HI-1:0];
                    timer_d      = '0;
                    if (miss) begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                        state_d = StResp;
                    end else begin
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                bus.tgt_req      = 1'b1;
                bus.tgt_sel[idx] = 1'b1;
                bus.tgt_addr     = addr_q[WIN_W-1:0];
                // Ack takes priority over a timeout landing in the same cycle.
                if (sel_ack) begin
                    rdata_d = sel_rdata;
                    rresp_d = RESP_OKAY;
                    state_d = StResp;
                end else if (timer_q + 1'b1 == TO) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StResp: begin
                if (!bus.r_wr_full) begin
                    bus.r_wr_en = 1'b1;
                    if (rresp_q != RESP_OKAY) begin
                        err_d = sat_inc(err_q);
                    end
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_axi4_bus_rd_sequencer.sv
// Randomized self-checking bench for axi4_bus_rd_sequencer with a transaction-level model.
module tb_axi4_bus_rd_sequencer;

    localparam int unsigned A       = 32;
    localparam int unsigned D       = 32;
    localparam int unsigned N       = 4;
    localparam int unsigned WIN_W   = 12;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned IW      = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   err_model   = 0;

    axi4_bus_rd_sequencer_if #(.A(A), .D(D), .N(N), .WIN_W(WIN_W)) bus ();

    axi4_bus_rd_sequencer #(
        .A(A), .D(D), .N(N), .WIN_W(WIN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic bit is_miss(input logic [A-1:0] a);
        return (a >> (WIN_W + IW)) != 0;
    endfunction

    function automatic int idx_of(input logic [A-1:0] a);
        return int'((a >> WIN_W) % N);
    endfunction

    // One full transaction: pop at cycle 0, then cycle-by-cycle checks up to the push.
    task automatic run_txn(input logic [A-1:0] addr, input int ack_at, input int full_cyc,
                           input bit keep_ne, input bit use_fixed, input logic [D-1:0] fixed,
                           input string name);
        bit           miss;
        int           idx, nreq, push;
        logic [1:0]   exp_resp;
        logic [D-1:0] exp_data;
        logic [N-1:0] sel, ack;
        bit           exp_req;
        miss     = is_miss(addr);
        idx      = idx_of(addr);
        sel      = '0;
        sel[idx] = 1'b1;
        exp_data = '0;
        if (miss) begin
            nreq = 0; exp_resp = 2'b11;
        end else if (ack_at >= 1 && ack_at <= int'(TIMEOUT)) begin
            nreq = ack_at; exp_resp = 2'b00;
        end else begin
            nreq = TIMEOUT; exp_resp = 2'b10;
        end
        push = 1 + nreq + full_cyc;

        @(negedge clk);
        bus.araddr = addr; bus.ar_rd_empty = 1'b0; bus.tgt_ack = '0; bus.r_wr_full = 1'b0;
        #1;
        vectors++;
        if (bus.ar_rd_en !== 1'b1 || bus.r_wr_en !== 1'b0 || bus.tgt_req !== 1'b0 ||
            bus.err_count !== 8'(err_model)) begin
            miscompares++;
            $display("FAIL %s pop: ar_rd_en=%b r_wr_en=%b tgt_req=%b err=%0d, need 1 0 0 %0d",
                     name, bus.ar_rd_en, bus.r_wr_en, bus.tgt_req, bus.err_count, err_model);
        end

        for (int c = 1; c <= push; c++) begin
            @(negedge clk);
            bus.ar_rd_empty = !keep_ne;
            for (int t = 0; t < int'(N); t++) bus.tgt_rdata[t*D +: D] = $urandom;
            bus.r_wr_full = (c > nreq) && (c < push);
            ack = (c % 2 == 1) ? ~sel : (N'($urandom) & ~sel);
            if (!miss && c == ack_at && ack_at <= int'(TIMEOUT)) begin
                ack[idx] = 1'b1;
                if (use_fixed) bus.tgt_rdata[idx*D +: D] = fixed;
                exp_data = bus.tgt_rdata[idx*D +: D];
            end
            bus.tgt_ack = ack;
            #1;
            exp_req = !miss && (c <= nreq);
            vectors++;
            if (bus.tgt_req !== exp_req || bus.tgt_sel !== (exp_req ? sel : '0) ||
                (exp_req && bus.tgt_addr !== addr[WIN_W-1:0])) begin
                miscompares++;
                $display("FAIL %s cyc%0d tgt: req=%b sel=%b addr=%h, need %b %b %h", name, c,
                         bus.tgt_req, bus.tgt_sel, bus.tgt_addr, exp_req,
                         exp_req ? sel : '0, addr[WIN_W-1:0]);
            end
            vectors++;
            if (bus.ar_rd_en !== 1'b0 || bus.r_wr_en !== (c == push) ||
                bus.err_count !== 8'(err_model)) begin
                miscompares++;
                $display("FAIL %s cyc%0d strobes: ar_rd_en=%b r_wr_en=%b err=%0d, need 0 %b %0d",
                         name, c, bus.ar_rd_en, bus.r_wr_en, bus.err_count, c == push,
                         err_model);
            end
            if (c > nreq) begin
                vectors++;
                if (bus.rdata !== exp_data || bus.rresp !== exp_resp) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d resp: rdata=%h rresp=%0d, need %h %0d", name, c,
                             bus.rdata, bus.rresp, exp_data, exp_resp);
                end
            end
        end
        bus.tgt_ack = '0;
        if (exp_resp != 2'b00 && err_model < 255) err_model++;
    endtask

    task automatic test_reset();
        bus.ar_rd_empty = 1'b1; bus.araddr = '0; bus.r_wr_full = 1'b0;
        bus.tgt_ack = '0; bus.tgt_rdata = '0;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.ar_rd_en !== 1'b0 || bus.r_wr_en !== 1'b0 || bus.tgt_req !== 1'b0 ||
            bus.tgt_sel !== '0 || bus.tgt_addr !== '0 || bus.rdata !== '0 ||
            bus.rresp !== 2'b00 || bus.err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset outputs: en=%b%b req=%b sel=%b addr=%h rdata=%h rresp=%0d err=%0d, need all zero",
                     bus.ar_rd_en, bus.r_wr_en, bus.tgt_req, bus.tgt_sel, bus.tgt_addr,
                     bus.rdata, bus.rresp, bus.err_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        err_model = 0;
    endtask

    task automatic test_okay();
        run_txn(32'h0000_1004, 1, 0, 1'b0, 1'b1, 32'hCAFE_F00D, "okay_min_latency");
    endtask

    task automatic test_decerr();
        run_txn(32'h8000_0000, 0, 0, 1'b0, 1'b0, '0, "decerr");
    endtask

    task automatic test_timeout();
        run_txn(32'h0000_2000, 0, 0, 1'b0, 1'b0, '0, "timeout_slverr");
        run_txn(32'h0000_2000, 4, 0, 1'b0, 1'b0, '0, "ack_on_timeout_cycle");
    endtask

    task automatic test_backpressure();
        run_txn(32'h0000_3abc, 2, 5, 1'b1, 1'b0, '0, "backpressure");
        run_txn(32'h0000_0010, 1, 0, 1'b0, 1'b0, '0, "after_backpressure");
    endtask

    task automatic test_ignore_other_ack();
        run_txn(32'h0000_0040, 0, 0, 1'b0, 1'b0, '0, "ignore_other_ack");
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) begin
            run_txn({1'b1, 31'($urandom)}, 0, 0, 1'b0, 1'b0, '0, "saturate");
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.err_count !== 8'(err_model) || err_model != 255) begin
            miscompares++;
            $display("FAIL err_saturate: err_count=%0d, need 255", bus.err_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.araddr = 32'h0000_2000; bus.ar_rd_empty = 1'b0;
        @(negedge clk);
        bus.ar_rd_empty = 1'b1;
        #1;
        vectors++;
        if (bus.tgt_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid pre: tgt_req=%b, need 1", bus.tgt_req);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.tgt_req !== 1'b0 || bus.tgt_sel !== '0 || bus.tgt_addr !== '0 ||
            bus.r_wr_en !== 1'b0 || bus.ar_rd_en !== 1'b0 || bus.rdata !== '0 ||
            bus.rresp !== 2'b00 || bus.err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid async: req=%b sel=%b addr=%h wr=%b rd=%b rdata=%h rresp=%0d err=%0d, need zero",
                     bus.tgt_req, bus.tgt_sel, bus.tgt_addr, bus.r_wr_en, bus.ar_rd_en,
                     bus.rdata, bus.rresp, bus.err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        err_model = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (bus.r_wr_en !== 1'b0 || bus.tgt_req !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid abandon cyc%0d: r_wr_en=%b tgt_req=%b, need 0 0",
                         c, bus.r_wr_en, bus.tgt_req);
            end
        end
        run_txn(32'h0000_1008, 3, 1, 1'b0, 1'b0, '0, "after_reset");
    endtask

    task automatic test_random();
        logic [A-1:0] a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom & 32'h3fff);
            run_txn(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), 1'b0, '0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_txn(A'($urandom & 32'h3fff), 1, 0, 1'b1, 1'b0, '0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_okay();
        test_decerr();
        test_timeout();
        test_backpressure();
        test_ignore_other_ack();
        test_back_to_back();
        test_err_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_bus_rd_sequencer.md
AXI4_BUS_RD_SEQUENCER -- requirements
Module: axi4_bus_rd_sequencer

Interface
REQ-001 Parameter A, default 32, address width.
REQ-002 Parameter D, default 32, read data width.
REQ-003 Parameter N, default 4, number of register targets (power of 2, >=2).
REQ-004 Parameter WIN_W, default 12, log2 bytes of each target address window.
REQ-005 Parameter TIMEOUT, default 255, max REQ cycles waiting for ack (1..255).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ar_rd_empty  in  1  AR FIFO empty flag.
REQ-009 ar_rd_en  out  1  AR FIFO pop strobe.
REQ-010 araddr  in  A  AR FIFO head address.
REQ-011 r_wr_full  in  1  R FIFO full flag.
REQ-012 r_wr_en  out  1  R FIFO push strobe.
REQ-013 rdata  out  D  R FIFO write data.
REQ-014 rresp  out  2  R FIFO write response.
REQ-015 tgt_req  out  1  read request to selected target.
REQ-016 tgt_sel  out  N  one-hot target select.
REQ-017 tgt_addr  out  WIN_W  offset within target window.
REQ-018 tgt_ack  in  N  per-target ack, rdata valid same cycle.
REQ-019 tgt_rdata  in  N*D  per-target read data, target i at bits [i*D +: D].
REQ-020 err_count  out  8  saturating count of error responses.

Function
REQ-021 States SHALL be IDLE, REQ, RESP only.
REQ-022 IDLE with ar_rd_empty=0: ar_rd_en=1 for exactly one cycle, araddr latched, next state REQ (decoded hit) or RESP (decode miss).
REQ-023 Decode: idx = araddr[WIN_W +: log2(N)]; miss when any araddr bit above WIN_W+log2(N)-1 is 1.
REQ-024 Miss: rresp=2'b11 (DECERR), rdata=0, no tgt_req issued.
REQ-025 REQ: tgt_req=1, tgt_sel one-hot on idx, tgt_addr=latched araddr[WIN_W-1:0]; all three held stable until leaving REQ.
REQ-026 tgt_ack[idx]=1 in REQ: capture tgt_rdata slice idx, rresp=2'b00 (OKAY), next RESP.
REQ-027 tgt_ack bits for non-selected targets SHALL be ignored.
REQ-028 Timer cleared on REQ entry, increments each REQ cycle; on TIMEOUT-th REQ cycle without ack: rresp=2'b10 (SLVERR), rdata=0, next RESP.
REQ-029 Ack and timeout in same cycle: ack wins, OKAY.
REQ-030 RESP: r_wr_en=1 when r_wr_full=0, next IDLE; while r_wr_full=1, r_wr_en=0, rdata/rresp held, stay RESP.
REQ-031 Outside IDLE ar_rd_en=0; outside RESP r_wr_en=0; outside REQ tgt_req=0, tgt_sel=0.
REQ-032 ar_rd_en and r_wr_en are combinational from state and FIFO flags; never asserted while empty/full.
REQ-033 Minimum latency: pop cycle 0, REQ cycle 1 with ack, push cycle 2; one transaction in flight; next pop earliest cycle 3.
REQ-034 DECERR latency: pop cycle 0, push cycle 1.
REQ-035 err_count increments by 1 on each push with rresp!=OKAY; saturates at 255.

Reset
REQ-036 Reset SHALL force IDLE, timer=0, err_count=0, latched address/rdata=0, rresp=2'b00.
REQ-037 Reset outputs: ar_rd_en=0, r_wr_en=0, tgt_req=0, tgt_sel=0, tgt_addr=0, rdata=0, rresp=0.
REQ-038 Reset mid-transaction SHALL abandon it with no push; a popped AR entry is lost.

Structure
REQ-039 State enum and RESP_OKAY/RESP_SLVERR/RESP_DECERR constants SHALL live in package axi4_bus_rd_sequencer_pkg.
REQ-040 Single flat module; no sub-module; interfaces directly to axi4_bus_rd_fifos FIFO ports.

Verification
REQ-041 araddr=0x1004, tgt_ack[1] on first REQ cycle, tgt_rdata slice1=0xCAFEF00D -> push cycle 2, rdata=0xCAFEF00D, rresp=0, tgt_addr=0x004.
REQ-042 araddr=0x8000_0000 -> no tgt_req, push cycle 1, rdata=0, rresp=3, err_count=1.
REQ-043 araddr=0x2000, no ack, TIMEOUT=4 -> tgt_req for exactly 4 cycles, push rresp=2, rdata=0; ack on 4th cycle instead -> rresp=0.
REQ-044 r_wr_full=1 for 5 cycles in RESP -> r_wr_en=0, outputs stable, push on first not-full cycle, no new pop meanwhile.
REQ-045 tgt_ack[2] asserted while idx=0 selected -> ignored, timeout SLVERR; 300 errors -> err_count=255.
REQ-046 reset asserted during REQ -> all outputs zero immediately, no push, next AR entry serviced normally after release.
